// File: rtl/apb_cmd_master.sv
// APB requester: turns one valid/ready command into one SETUP/ACCESS transfer
// and returns read data, slave error and timeout status on a response port.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Abort is taken on the cycle whose PREADY=0 sample would bring the
  // counter to TIMEOUT-1, so ACCESS lasts at most TIMEOUT-1 cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 2);

  logic [1:0] state;
  logic [7:0] wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= S_IDLE;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and APB strobes are pure state decode, so reset clears them at once.
  assign cmd_ready = (state == S_IDLE);
  assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE   = (state == S_ACCESS);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master against a small OR-accumulator APB slave model
// with registered PREADY.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, busy;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  // Slave: DATA writes OR into acc, CONTROL bit0 copies acc to RESULT,
  // RESULT is read-only, anything at 0xC or above errors.
  logic        pready_r, pslverr_r, stall, late;
  logic [31:0] prdata_r, acc, result;

  always @(posedge PCLK) begin
    if (PRESET) begin
      acc <= '0; result <= '0; prdata_r <= '0;
      pready_r <= 1'b0; pslverr_r <= 1'b0;
    end else begin
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      if (PSEL && PENABLE && !pready_r && !stall) begin
        pready_r <= 1'b1;
        prdata_r <= '0;
        if (PWRITE) begin
          case (PADDR)
            32'h0:   acc <= acc | PWDATA;
            32'h4:   if (PWDATA[0]) result <= acc;
            default: pslverr_r <= 1'b1;
          endcase
        end else begin
          case (PADDR)
            32'h0:   prdata_r <= acc;
            32'h4:   prdata_r <= '0;
            32'h8:   prdata_r <= result;
            default: pslverr_r <= 1'b1;
          endcase
        end
      end
    end
  end

  assign PREADY  = pready_r | late;
  assign PSLVERR = pslverr_r | late;
  assign PRDATA  = late ? 32'hDEAD_BEEF : prdata_r;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One full command/response exchange with rsp_ready asserted on arrival.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output logic to,
                      output int lat, output int pen_cnt, output int hold_bad);
    int guard;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge PCLK); guard++; end
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    lat = 1; pen_cnt = 0; hold_bad = 0;
    while (!rsp_valid && lat < 300) begin
      if (PENABLE) pen_cnt++;
      if (PSEL && (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wd))) hold_bad++;
      @(negedge PCLK);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        tout;
    int          lat;
    int          pen;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic        er, to;
    int          lat, pen, hb, bad, guard;

    vecs[0] = '{"wr_data_f0", 1'b1, 32'h0, 32'h0000_00F0, 32'h0,         1'b0, 1'b0, 4, 2};
    vecs[1] = '{"wr_data_0f", 1'b1, 32'h0, 32'h0000_000F, 32'h0,         1'b0, 1'b0, 4, 2};
    vecs[2] = '{"wr_ctrl",    1'b1, 32'h4, 32'h0000_0001, 32'h0,         1'b0, 1'b0, 4, 2};
    vecs[3] = '{"rd_result",  1'b0, 32'h8, 32'h1234_5678, 32'h0000_00FF, 1'b0, 1'b0, 4, 2};
    vecs[4] = '{"wr_result",  1'b1, 32'h8, 32'h0000_0055, 32'h0,         1'b1, 1'b0, 4, 2};
    vecs[5] = '{"rd_bad_c",   1'b0, 32'hC, 32'h0,         32'h0,         1'b1, 1'b0, 4, 2};
    vecs[6] = '{"rd_data",    1'b0, 32'h0, 32'h0,         32'h0000_00FF, 1'b0, 1'b0, 4, 2};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; stall = 1'b0; late = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_psel",      {30'd0, PSEL, PENABLE}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_paddr",     PADDR,  32'h0);
    chk("rst_pwdata",    PWDATA, 32'h0);
    chk("rst_rsp",       {29'd0, rsp_err, rsp_timeout, PWRITE} | rsp_rdata, 32'd0);

    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, to, lat, pen, hb);
      chk({vecs[i].nm, "_rdata"},   rd,                vecs[i].rdata);
      chk({vecs[i].nm, "_err"},     {31'd0, er},       {31'd0, vecs[i].err});
      chk({vecs[i].nm, "_timeout"}, {31'd0, to},       {31'd0, vecs[i].tout});
      chk({vecs[i].nm, "_latency"}, lat,               vecs[i].lat);
      chk({vecs[i].nm, "_access"},  pen,               vecs[i].pen);
      chk({vecs[i].nm, "_hold"},    hb,                0);
    end

    // Slave never answers: abort after 15 ACCESS cycles, then a stray PREADY.
    stall = 1'b1;
    xfer(1'b0, 32'h8, 32'h0, rd, er, to, lat, pen, hb);
    stall = 1'b0;
    chk("tmo_rdata",   rd,          32'h0);
    chk("tmo_err",     {31'd0, er}, 32'd1);
    chk("tmo_timeout", {31'd0, to}, 32'd1);
    chk("tmo_access",  pen,         15);
    chk("tmo_latency", lat,         17);
    late = 1'b1;
    @(negedge PCLK);
    late = 1'b0;
    bad = 0;
    repeat (6) begin
      if (rsp_valid || busy) bad++;
      @(negedge PCLK);
    end
    chk("tmo_late_ready", bad, 0);

    // Response back-pressure with a second command already waiting.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = '0;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge PCLK); guard++; end
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h0000_0100;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(negedge PCLK); guard++; end
    chk("bp_rdata", rsp_rdata, 32'h0000_00FF);
    bad = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (!rsp_valid || rsp_rdata !== 32'h0000_00FF || rsp_err || rsp_timeout ||
          cmd_ready || PSEL || PENABLE) bad++;
    end
    chk("bp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    chk("bp_idle_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk("bp_next_setup", {29'd0, PSEL, PENABLE, PWRITE}, 32'd5);
    chk("bp_next_wdata", PWDATA, 32'h0000_0100);
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(negedge PCLK); guard++; end
    chk("bp_next_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    @(negedge PCLK);
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of ACCESS.
    stall = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h0000_0ABC;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge PCLK); guard++; end
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("ar_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    #2 PRESET = 1'b1;
    #1;
    chk("ar_immediate", {28'd0, PSEL, PENABLE, rsp_valid, busy}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    stall  = 1'b0;
    @(negedge PCLK);
    chk("ar_after", {30'd0, busy, cmd_ready}, 32'd1);
    chk("ar_paddr", PADDR, 32'h0);
    bad = 0;
    repeat (20) begin
      if (rsp_valid || PSEL) bad++;
      @(negedge PCLK);
    end
    chk("ar_no_rsp", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
